dct_coef_quantizer: RTL

//  Downstream stage of the 2-D DCT unit. Consumes one transposed 16-coefficient row per valid cycle
//  (16 x 12-bit signed), quantizes each coefficient by a position-dependent power-of-two step, and

---
 rtl/dct_coef_quantizer_if.sv | 26 ++
 rtl/dct_coef_quantizer.sv | 137 +++++++++++++
 2 files changed

// File: rtl/dct_coef_quantizer_if.sv
// Row bus between the DCT transpose stage, the coefficient quantizer and the packing stage.
interface dct_coef_quantizer_if #(
    parameter int unsigned N  = 16,
    parameter int unsigned CW = 12,
    parameter int unsigned QW = 8
);
    logic [N*CW-1:0] coef_in;
    logic            in_valid;
    logic [3:0]      qp;
    logic [N*QW-1:0] q_out;
    logic            out_valid;
    logic [3:0]      row_idx;
    logic            blk_end;

    // Upstream/bench view: drives rows, observes quantized output.
    modport master (
        output coef_in, in_valid, qp,
        input  q_out, out_valid, row_idx, blk_end
    );

    // Quantizer view.
    modport slave (
        input  coef_in, in_valid, qp,
        output q_out, out_valid, row_idx, blk_end
    );
endinterface

// File: rtl/dct_coef_quantizer.sv
// Quantizes one 16-coefficient DCT row per valid cycle by a position-dependent power-of-two step,
// rounding half away from zero and saturating symmetrically to [-127,127]. Two-cycle pipeline.
module dct_coef_quantizer #(
    parameter int unsigned N    = 16,
    parameter int unsigned CW   = 12,
    parameter int unsigned QW   = 8,
    parameter int unsigned SMAX = 11
) (
    input  logic                  clk,
    input  logic                  rstn,
    dct_coef_quantizer_if.slave   bus
);
    localparam int unsigned MW = CW + 2;  // magnitude plus rounding headroom
    localparam logic [MW-1:0] MaxMag = MW'((1 << (QW - 1)) - 1);
    localparam logic [MW-1:0] One    = MW'(1);

    // Block position and per-block quantizer base
    logic [3:0] row_q, row_d;
    logic [3:0] qp_blk_q, qp_blk_d;
    logic [3:0] qp_eff;

    // Stage 1
    logic                s1_valid_q, s1_valid_d;
    logic [3:0]          s1_row_q, s1_row_d;
    logic                s1_last_q, s1_last_d;
    logic [N-1:0]        s1_sign_q, s1_sign_d;
    logic [N-1:0][CW:0]  s1_mag_q, s1_mag_d;
    logic [N-1:0][3:0]   s1_shift_q, s1_shift_d;

    // Stage 2 (outputs)
    logic                out_valid_q, out_valid_d;
    logic [3:0]          row_idx_q, row_idx_d;
    logic                blk_end_q, blk_end_d;
    logic [N*QW-1:0]     q_out_q, q_out_d;

    // Row counter, qp capture at block start, and sign/magnitude/shift decode per lane
    always_comb begin
        logic [CW-1:0] x;
        logic [CW:0]   xe;
        logic [4:0]    rc;
        logic [4:0]    sum;

        row_d      = row_q;
        qp_blk_d   = qp_blk_q;
        // Row 0 uses the live qp; later rows use the value captured at row 0.
        qp_eff     = (row_q == 4'd0) ? bus.qp : qp_blk_q;
        s1_valid_d = bus.in_valid;
        s1_row_d   = s1_row_q;
        s1_last_d  = s1_last_q;
        s1_sign_d  = s1_sign_q;
        s1_mag_d   = s1_mag_q;
        s1_shift_d = s1_shift_q;
        x          = '0;
        xe         = '0;
        rc         = '0;
        sum        = '0;

        if (bus.in_valid) begin
            row_d     = row_q + 4'd1;
            qp_blk_d  = qp_eff;
            s1_row_d  = row_q;
            s1_last_d = (row_q == 4'd15);
            for (int c = 0; c < N; c++) begin
                x  = bus.coef_in[CW*c +: CW];
                xe = {x[CW-1], x};
                s1_sign_d[c] = x[CW-1];
                // -2048 maps to +2048 thanks to the extra magnitude bit.
                s1_mag_d[c]  = x[CW-1] ? ((CW+1)'(0) - xe) : xe;
                rc  = {1'b0, row_q} + 5'(c);
                sum = {1'b0, qp_eff} + {3'b000, rc[4:3]};
                s1_shift_d[c] = (sum > 5'(SMAX)) ? 4'(SMAX) : sum[3:0];
            end
        end
    end

    // Round half away from zero, shift, saturate, restore sign
    always_comb begin
        logic [MW-1:0] m;
        logic [QW-1:0] mq;

        out_valid_d = s1_valid_q;
        row_idx_d   = row_idx_q;
        blk_end_d   = blk_end_q;
        q_out_d     = q_out_q;
        m           = '0;
        mq          = '0;

        if (s1_valid_q) begin
            row_idx_d = s1_row_q;
            blk_end_d = s1_last_q;
            for (int c = 0; c < N; c++) begin
                m = {1'b0, s1_mag_q[c]};
                if (s1_shift_q[c] != 4'd0) begin
                    m = (m + (One << (s1_shift_q[c] - 4'd1))) >> s1_shift_q[c];
                end
                mq = (m > MaxMag) ? MaxMag[QW-1:0] : m[QW-1:0];
                q_out_d[QW*c +: QW] = s1_sign_q[c] ? ({QW{1'b0}} - mq) : mq;
            end
        end
    end

    // Pipeline and block-position state
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            row_q       <= '0;
            qp_blk_q    <= '0;
            s1_valid_q  <= 1'b0;
            s1_row_q    <= '0;
            s1_last_q   <= 1'b0;
            s1_sign_q   <= '0;
            s1_mag_q    <= '0;
            s1_shift_q  <= '0;
            out_valid_q <= 1'b0;
            row_idx_q   <= '0;
            blk_end_q   <= 1'b0;
            q_out_q     <= '0;
        end else begin
            row_q       <= row_d;
            qp_blk_q    <= qp_blk_d;
            s1_valid_q  <= s1_valid_d;
            s1_row_q    <= s1_row_d;
            s1_last_q   <= s1_last_d;
            s1_sign_q   <= s1_sign_d;
            s1_mag_q    <= s1_mag_d;
            s1_shift_q  <= s1_shift_d;
            out_valid_q <= out_valid_d;
            row_idx_q   <= row_idx_d;
            blk_end_q   <= blk_end_d;
            q_out_q     <= q_out_d;
        end
    end

    assign bus.q_out     = q_out_q;
    assign bus.out_valid = out_valid_q;
    assign bus.row_idx   = row_idx_q;
    assign bus.blk_end   = blk_end_q;
endmodule
